// File: rtl/adc_pll_reset_ctrl.sv
// ADC PLL reset/lock sequencer: pulses the PLL reset, waits for lock with a timeout,
// qualifies lock as stable, then releases the ADC reset; re-runs on lock loss or restart.
module adc_pll_reset_ctrl #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             restart,
  output logic             pll_rst,
  output logic             adc_rst_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [1:0]       state
);
  // state     | meaning
  // RST_PLL   | PLL reset held for RST_PULSE_CYC cycles
  // WAIT_LOCK | waiting for synced lock, bounded by LOCK_TIMEOUT_CYC
  // STABLE    | lock must hold LOCK_STABLE_CYC consecutive cycles
  // RUN       | ADC reset released, ready high
  localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYC) ? MAX_A : LOCK_STABLE_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_RST_PLL   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [1:0]       r_rst_sync;
  logic             r_lock_meta;
  logic             r_lock_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_tmr;
  logic [TW-1:0]    w_tmr_nxt;
  logic             w_retry_inc;
  logic             w_loss_inc;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             r_pll_rst;
  logic             r_adc_rst_n;
  logic             r_ready;
  logic             r_lock_lost;
  logic             w_tc_pulse;
  logic             w_tc_timeout;
  logic             w_tc_stable;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync  <= 2'b00;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_rst_sync  <= {r_rst_sync[0], 1'b1};
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_tc_pulse   = (r_tmr == TW'(RST_PULSE_CYC - 1));
  assign w_tc_timeout = (r_tmr == TW'(LOCK_TIMEOUT_CYC - 1));
  assign w_tc_stable  = (r_tmr == TW'(LOCK_STABLE_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    // Pulse timing starts on the first edge after release; transitions wait for the full sync.
    if (!r_rst_sync[1]) begin
      w_tmr_nxt = r_rst_sync[0] ? r_tmr + TW'(1) : '0;
    end else if (restart) begin
      w_state_nxt = S_RST_PLL;
      w_tmr_nxt   = '0;
    end else begin
      unique case (r_state)
        S_RST_PLL: begin
          if (w_tc_pulse) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = S_STABLE;
            w_tmr_nxt   = '0;
          end else if (w_tc_timeout) begin
            w_state_nxt = S_RST_PLL;
            w_tmr_nxt   = '0;
            w_retry_inc = 1'b1;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_tmr_nxt   = '0;
          end else if (w_tc_stable) begin
            w_state_nxt = S_RUN;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + TW'(1);
          end
        end
        S_RUN: begin
          w_tmr_nxt = '0;
          if (!r_lock_s) begin
            w_state_nxt = S_RST_PLL;
            w_loss_inc  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_RST_PLL;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RST_PLL;
      r_tmr       <= '0;
      r_pll_rst   <= 1'b1;
      r_adc_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_pll_rst   <= (w_state_nxt == S_RST_PLL);
      r_adc_rst_n <= (w_state_nxt == S_RUN);
      r_ready     <= (w_state_nxt == S_RUN);
      r_lock_lost <= w_loss_inc;
      if (w_retry_inc && (r_retry_cnt != '1)) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
      if (w_loss_inc && (r_loss_cnt != '1))   r_loss_cnt  <= r_loss_cnt + CNT_W'(1);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign adc_rst_n = r_adc_rst_n;
  assign ready     = r_ready;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_adc_pll_reset_ctrl.sv
// Bench for adc_pll_reset_ctrl: phase/age reference model checked every cycle, plus
// directed scenarios with hand-computed latencies, pulse widths and counter values.
module tb_adc_pll_reset_ctrl;
  localparam int PULSE = 4;
  localparam int TMO   = 50;
  localparam int STB   = 8;
  localparam int CW    = 8;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pll_locked = 1'b0;
  logic          restart = 1'b0;
  logic          pll_rst, adc_rst_n, ready, lock_lost;
  logic [CW-1:0] retry_cnt, loss_cnt;
  logic [1:0]    state;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 refclk = ~refclk;

  adc_pll_reset_ctrl #(
    .RST_PULSE_CYC(PULSE), .LOCK_TIMEOUT_CYC(TMO), .LOCK_STABLE_CYC(STB), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .adc_rst_n(adc_rst_n), .ready(ready), .lock_lost(lock_lost),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  // Reference model: phase 0..3, cycles spent in phase, lock seen two edges late.
  int m_rel = 0, m_ph = 0, m_age = 0, m_retry = 0, m_loss = 0;
  bit m_q1 = 1'b0, m_q2 = 1'b0, m_ll = 1'b0, m_ls;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_rel = 0; m_ph = 0; m_age = 0; m_retry = 0; m_loss = 0;
      m_q1 = 1'b0; m_q2 = 1'b0; m_ll = 1'b0;
    end else begin
      m_ls = m_q2;
      m_q2 = m_q1;
      m_q1 = pll_locked;
      m_ll = 1'b0;
      if (m_rel < 2) begin
        if (m_rel == 1) m_age++;
        m_rel++;
      end else if (restart) begin
        m_ph = 0; m_age = 0;
      end else begin
        m_age++;
        case (m_ph)
          0: if (m_age >= PULSE) begin m_ph = 1; m_age = 0; end
          1: if (m_ls) begin m_ph = 2; m_age = 0; end
             else if (m_age >= TMO) begin
               m_ph = 0; m_age = 0;
               if (m_retry < 255) m_retry++;
             end
          2: if (!m_ls) begin m_ph = 1; m_age = 0; end
             else if (m_age >= STB) begin m_ph = 3; m_age = 0; end
          default: if (!m_ls) begin
               m_ph = 0; m_age = 0; m_ll = 1'b1;
               if (m_loss < 255) m_loss++;
             end
        endcase
      end
    end
  end

  always @(negedge refclk) begin
    if (chk_en) begin
      logic [21:0] a_vec, e_vec;
      a_vec = {state, pll_rst, adc_rst_n, ready, lock_lost, retry_cnt, loss_cnt};
      e_vec = {2'(m_ph), (m_ph == 0), (m_ph == 3), (m_ph == 3), m_ll, CW'(m_retry), CW'(m_loss)};
      n_chk++;
      if (a_vec !== e_vec) begin
        n_fail++;
        $display("FAIL model_cmp @%0t: got {st,prst,arn,rdy,ll,retry,loss}=%h expected %h",
                 $time, a_vec, e_vec);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, input string name, output int k);
    k = 0;
    do begin
      @(negedge refclk);
      k++;
    end while (state != st && k < bound);
    n_chk++;
    if (state != st) begin
      n_fail++;
      $display("FAIL %s: state %0d expected %0d within %0d cycles", name, state, st, bound);
    end
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge refclk);
      if (pll_rst) n++;
      else break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, first, nll, np;
    bit saw;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge refclk);
    check("rst_state", state, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_adc_rst_n", adc_rst_n, 0);
    check("rst_retry", retry_cnt, 0);

    // 1: release, lock 10 cycles after pll_rst falls
    #2 rst_n = 1'b1;
    pulse_len(n);
    check("t1_pulse", n, 4);
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    wait_state(2'd3, 100, "t1_run", k);
    check("t1_ready_lat", k, 11);
    check("t1_ready", ready, 1);
    check("t1_adc_rst_n", adc_rst_n, 1);
    check("t1_retry", retry_cnt, 0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    first = -1; nll = 0; np = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge refclk);
      if (lock_lost) begin
        nll++;
        if (first < 0) first = i;
      end
      if (pll_rst) np++;
    end
    check("t4_ll_first", first, 3);
    check("t4_ll_count", nll, 1);
    check("t4_pulse", np, 4);
    check("t4_loss", loss_cnt, 1);
    check("t4_ready", ready, 0);

    // 3: short lock drop in STABLE
    pll_locked = 1'b1;
    wait_state(2'd2, 20, "t3_stable", k);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge refclk);
      if (state == 2'd1) saw = 1'b1;
    end
    pll_locked = 1'b1;
    k = 0;
    do begin
      @(negedge refclk);
      k++;
      if (state == 2'd1) saw = 1'b1;
    end while (state != 2'd3 && k < 100);
    check("t3_saw_wait", saw, 1);
    check("t3_ready_lat", k, 11);
    check("t3_retry", retry_cnt, 0);

    // 5: restart coinciding with lock loss in RUN
    pll_locked = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    check("t5_state", state, 0);
    nll = lock_lost;
    for (int i = 0; i < 8; i++) begin
      @(negedge refclk);
      if (lock_lost) nll++;
    end
    check("t5_ll", nll, 0);
    check("t5_loss", loss_cnt, 1);

    // 2: no lock, retry loop to saturation
    k = 0;
    while (retry_cnt != 1 && k < 200) begin @(negedge refclk); k++; end
    check("t2_first_retry", retry_cnt, 1);
    k = 0;
    while (retry_cnt != 2 && k < 200) begin @(negedge refclk); k++; end
    check("t2_period", k, 54);
    k = 0;
    while (retry_cnt != 255 && k < 300 * 54) begin @(negedge refclk); k++; end
    check("t2_sat_reach", retry_cnt, 255);
    repeat (200) @(negedge refclk);
    check("t2_sat_hold", retry_cnt, 255);
    check("t2_loss", loss_cnt, 1);

    // 6: rst_n asserted mid-STABLE
    pll_locked = 1'b1;
    wait_state(2'd2, 100, "t6_stable", k);
    repeat (2) @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_state", state, 0);
    check("t6_async_pll_rst", pll_rst, 1);
    check("t6_async_adc_rst_n", adc_rst_n, 0);
    check("t6_async_ready", ready, 0);
    check("t6_async_retry", retry_cnt, 0);
    check("t6_async_loss", loss_cnt, 0);
    @(negedge refclk);
    #2 rst_n = 1'b1;
    pulse_len(n);
    check("t6_pulse", n, 4);
    wait_state(2'd3, 100, "t6_run", k);
    check("t6_ready_lat", k, 9);
    check("t6_retry", retry_cnt, 0);

    repeat (3) @(negedge refclk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
